// File: rtl/mkmif_gen_core.sv
// mkmif_gen_core: SPI master for the serial key SRAM. Runs the mode-register init
// frame after reset, then performs one word read or write per accepted command.
module mkmif_gen_core #(
   parameter int unsigned DATA_BYTES = 4,
   parameter int unsigned ADDR_BYTES = 2,
   parameter int unsigned DIV_WIDTH  = 16,
   parameter logic [7:0]  INIT_MODE  = 8'h41
) (
   input  logic                    clk_i,
   input  logic                    reset_i,
   output logic                    spi_sclk_o,
   output logic                    spi_cs_n_o,
   input  logic                    spi_do_i,
   output logic                    spi_di_o,
   input  logic                    read_op_i,
   input  logic                    write_op_i,
   output logic                    ready_o,
   output logic                    valid_o,
   input  logic [DIV_WIDTH-1:0]    sclk_div_i,
   input  logic [8*ADDR_BYTES-1:0] addr_i,
   input  logic [8*DATA_BYTES-1:0] write_data_i,
   output logic [8*DATA_BYTES-1:0] read_data_o
);

   localparam int unsigned DW = 8 * DATA_BYTES;
   localparam int unsigned AW = 8 * ADDR_BYTES;
   localparam int unsigned FW = 8 + AW + DW;          // longest frame (read/write)
   localparam int unsigned CW = $clog2(FW) + 1;

   typedef enum logic [2:0] {StInit, StReady, StLoad, StShift, StDone} state_e;
   typedef enum logic [1:0] {KindInit, KindRead, KindWrite} kind_e;

   state_e               state_q, state_d;
   kind_e                kind_q, kind_d;
   logic [DIV_WIDTH-1:0] div_cap_q, div_cap_d;   // divider captured at accept/init
   logic [DIV_WIDTH-1:0] div_q, div_d;           // divider in use for current frame
   logic [DIV_WIDTH-1:0] div_cnt_q, div_cnt_d;
   logic [AW-1:0]        addr_q, addr_d;
   logic [DW-1:0]        wdata_q, wdata_d;
   logic [FW-1:0]        frame_q, frame_d;
   logic [CW-1:0]        bit_cnt_q, bit_cnt_d;
   logic [DW-1:0]        rx_q, rx_d;
   logic [DW-1:0]        rdata_q, rdata_d;
   logic                 sclk_q, sclk_d;
   logic                 cs_n_q, cs_n_d;
   logic                 di_q, di_d;
   logic                 valid_q, valid_d;
   logic                 init_tail_q, init_tail_d; // one extra DONE cycle after init

   logic [FW-1:0]        frame_ld;
   logic [CW-1:0]        n_ld;

   // State and datapath registers; reset forces the SPI bus idle and restarts init.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q     <= StInit;
         kind_q      <= KindInit;
         div_cap_q   <= '0;
         div_q       <= DIV_WIDTH'(1);
         div_cnt_q   <= '0;
         addr_q      <= '0;
         wdata_q     <= '0;
         frame_q     <= '0;
         bit_cnt_q   <= '0;
         rx_q        <= '0;
         rdata_q     <= '0;
         sclk_q      <= 1'b0;
         cs_n_q      <= 1'b1;
         di_q        <= 1'b0;
         valid_q     <= 1'b0;
         init_tail_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         kind_q      <= kind_d;
         div_cap_q   <= div_cap_d;
         div_q       <= div_d;
         div_cnt_q   <= div_cnt_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         frame_q     <= frame_d;
         bit_cnt_q   <= bit_cnt_d;
         rx_q        <= rx_d;
         rdata_q     <= rdata_d;
         sclk_q      <= sclk_d;
         cs_n_q      <= cs_n_d;
         di_q        <= di_d;
         valid_q     <= valid_d;
         init_tail_q <= init_tail_d;
      end
   end

   // Frame image and bit count for the pending transfer kind.
   always_comb begin
      frame_ld = '0;
      n_ld     = CW'(FW);
      case (kind_q)
         KindInit: begin
            frame_ld = {8'h01, INIT_MODE, {(FW-16){1'b0}}};
            n_ld     = CW'(16);
         end
         KindRead:  frame_ld = {8'h03, addr_q, {DW{1'b0}}};
         default:   frame_ld = {8'h02, addr_q, wdata_q};
      endcase
   end

   // Next-state logic: command accept, frame load and the bit serialiser.
   always_comb begin
      state_d     = state_q;
      kind_d      = kind_q;
      div_cap_d   = div_cap_q;
      div_d       = div_q;
      div_cnt_d   = div_cnt_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      frame_d     = frame_q;
      bit_cnt_d   = bit_cnt_q;
      rx_d        = rx_q;
      rdata_d     = rdata_q;
      sclk_d      = sclk_q;
      cs_n_d      = cs_n_q;
      di_d        = di_q;
      valid_d     = valid_q;
      init_tail_d = init_tail_q;

      // SRAM data is taken in the first cycle of each high SCLK phase.
      if (state_q == StShift && sclk_q && div_cnt_q == '0) begin
         rx_d = {rx_q[DW-2:0], spi_do_i};
      end

      unique case (state_q)
         StInit: begin
            kind_d    = KindInit;
            div_cap_d = sclk_div_i;
            state_d   = StLoad;
         end
         StReady: begin
            // Write has priority when both ops are raised together.
            if (write_op_i) begin
               kind_d    = KindWrite;
               addr_d    = addr_i;
               wdata_d   = write_data_i;
               div_cap_d = sclk_div_i;
               state_d   = StLoad;
            end else if (read_op_i) begin
               kind_d    = KindRead;
               addr_d    = addr_i;
               div_cap_d = sclk_div_i;
               valid_d   = 1'b0;
               state_d   = StLoad;
            end
         end
         StLoad: begin
            div_d     = (div_cap_q == '0) ? DIV_WIDTH'(1) : div_cap_q;
            div_cnt_d = '0;
            frame_d   = frame_ld;
            bit_cnt_d = n_ld;
            sclk_d    = 1'b0;
            cs_n_d    = 1'b0;
            di_d      = frame_ld[FW-1];
            state_d   = StShift;
         end
         StShift: begin
            if (div_cnt_q == div_q - DIV_WIDTH'(1)) begin
               div_cnt_d = '0;
               if (!sclk_q) begin
                  sclk_d = 1'b1;
               end else begin
                  sclk_d = 1'b0;
                  if (bit_cnt_q == CW'(1)) begin
                     cs_n_d  = 1'b1;
                     di_d    = 1'b0;
                     state_d = StDone;
                     if (kind_q == KindRead) begin
                        rdata_d = rx_d;
                        valid_d = 1'b1;
                     end
                     if (kind_q == KindInit) begin
                        init_tail_d = 1'b1;
                     end
                  end else begin
                     bit_cnt_d = bit_cnt_q - CW'(1);
                     frame_d   = {frame_q[FW-2:0], 1'b0};
                     di_d      = frame_q[FW-2];
                  end
               end
            end else begin
               div_cnt_d = div_cnt_q + DIV_WIDTH'(1);
            end
         end
         StDone: begin
            if (init_tail_q) begin
               init_tail_d = 1'b0;
            end else begin
               state_d = StReady;
            end
         end
         default: state_d = StInit;
      endcase
   end

   assign spi_sclk_o  = sclk_q;
   assign spi_cs_n_o  = cs_n_q;
   assign spi_di_o    = di_q;
   assign ready_o     = (state_q == StReady);
   assign valid_o     = valid_q;
   assign read_data_o = rdata_q;

endmodule

// File: tb/tb_mkmif_gen_core.sv
// Directed bench for mkmif_gen_core: default instance (A) plus an 8-byte word,
// 3-byte address instance (B), each attached to a behavioural serial SRAM.
module tb_mkmif_gen_core;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   always @(posedge clk) cyc++;

   // Instance A: 4-byte word, 2-byte address, 56-bit frames.
   logic        rst_a = 1'b1;
   logic        sclk_a, csn_a, di_a, rdy_a, vld_a;
   logic        do_a = 1'b0;
   logic        rd_a = 1'b0, wr_a = 1'b0;
   logic [15:0] div_a = 16'd1;
   logic [15:0] addr_a = '0;
   logic [31:0] wd_a = '0;
   logic [31:0] rdt_a;

   mkmif_gen_core dut_a (
      .clk_i(clk), .reset_i(rst_a), .spi_sclk_o(sclk_a), .spi_cs_n_o(csn_a),
      .spi_do_i(do_a), .spi_di_o(di_a), .read_op_i(rd_a), .write_op_i(wr_a),
      .ready_o(rdy_a), .valid_o(vld_a), .sclk_div_i(div_a), .addr_i(addr_a),
      .write_data_i(wd_a), .read_data_o(rdt_a)
   );

   // Instance B: 8-byte word, 3-byte address, 96-bit frames.
   logic        rst_b = 1'b1;
   logic        sclk_b, csn_b, di_b, rdy_b, vld_b;
   logic        do_b = 1'b0;
   logic        rd_b = 1'b0, wr_b = 1'b0;
   logic [15:0] div_b = 16'd1;
   logic [23:0] addr_b = '0;
   logic [63:0] wd_b = '0;
   logic [63:0] rdt_b;

   mkmif_gen_core #(.DATA_BYTES(8), .ADDR_BYTES(3)) dut_b (
      .clk_i(clk), .reset_i(rst_b), .spi_sclk_o(sclk_b), .spi_cs_n_o(csn_b),
      .spi_do_i(do_b), .spi_di_o(di_b), .read_op_i(rd_b), .write_op_i(wr_b),
      .ready_o(rdy_b), .valid_o(vld_b), .sclk_div_i(div_b), .addr_i(addr_b),
      .write_data_i(wd_b), .read_data_o(rdt_b)
   );

   // SRAM model A: shifts in on SCLK rise, drives data on SCLK fall.
   int           a_cnt = 0, a_last_n = 0;
   logic [127:0] a_sh = '0, a_last = '0;
   logic [31:0]  a_word = '0;
   logic [31:0]  mem_a [int];
   always @(negedge csn_a) begin a_cnt = 0; a_sh = '0; do_a = 1'b0; end
   always @(posedge sclk_a) if (csn_a === 1'b0) begin
      a_sh = {a_sh[126:0], di_a};
      a_cnt++;
      if (a_cnt == 24) a_word = mem_a.exists(int'(a_sh[15:0])) ? mem_a[int'(a_sh[15:0])] : '0;
   end
   always @(negedge sclk_a) if (csn_a === 1'b0 && a_cnt >= 24 && a_cnt < 56)
      do_a = a_word[31-(a_cnt-24)];
   always @(posedge csn_a) begin
      a_last = a_sh; a_last_n = a_cnt;
      if (a_cnt == 56 && a_sh[55:48] == 8'h02) mem_a[int'(a_sh[47:32])] = a_sh[31:0];
   end

   // SRAM model B.
   int           b_cnt = 0, b_last_n = 0;
   logic [127:0] b_sh = '0, b_last = '0;
   logic [63:0]  b_word = '0;
   logic [63:0]  mem_b [int];
   always @(negedge csn_b) begin b_cnt = 0; b_sh = '0; do_b = 1'b0; end
   always @(posedge sclk_b) if (csn_b === 1'b0) begin
      b_sh = {b_sh[126:0], di_b};
      b_cnt++;
      if (b_cnt == 32) b_word = mem_b.exists(int'(b_sh[23:0])) ? mem_b[int'(b_sh[23:0])] : '0;
   end
   always @(negedge sclk_b) if (csn_b === 1'b0 && b_cnt >= 32 && b_cnt < 96)
      do_b = b_word[63-(b_cnt-32)];
   always @(posedge csn_b) begin
      b_last = b_sh; b_last_n = b_cnt;
      if (b_cnt == 96 && b_sh[95:88] == 8'h02) mem_b[int'(b_sh[87:64])] = b_sh[63:0];
   end

   // SCLK period tracker for A, reset at every frame start.
   int   per_min = 1000000, per_max = 0, last_rise = 0;
   bit   have_rise = 1'b0;
   logic prev_sclk = 1'b0;
   always @(negedge csn_a) begin per_min = 1000000; per_max = 0; have_rise = 1'b0; end
   always @(posedge clk) begin
      if (sclk_a === 1'b1 && prev_sclk === 1'b0) begin
         if (have_rise) begin
            if (cyc - last_rise < per_min) per_min = cyc - last_rise;
            if (cyc - last_rise > per_max) per_max = cyc - last_rise;
         end
         last_rise = cyc;
         have_rise = 1'b1;
      end
      prev_sclk = sclk_a;
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // ready must never be high while chip select is active.
   always @(negedge clk) if (rst_a === 1'b0 && csn_a === 1'b0)
      chk("ready_during_frame", 128'(rdy_a), 128'd0);

   function automatic logic sig(input int sel);
      case (sel)
         0:       return csn_a;
         1:       return rdy_a;
         2:       return csn_b;
         default: return rdy_b;
      endcase
   endfunction

   task automatic wait_until(input int sel, input logic val, input string tag);
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (sig(sel) === val) return;
      end
      checks++;
      errors++;
      $error("FAIL %s: timeout, signal never reached %0b", tag, val);
   endtask

   // Present a command to A for one cycle; tn is the cycle count at the driving negedge.
   task automatic issue_a(input bit rd, input bit wr, input logic [15:0] ad,
                          input logic [31:0] wd, input logic [15:0] dv, output int tn);
      wait_until(1, 1'b1, "wait_ready_a");
      rd_a = rd; wr_a = wr; addr_a = ad; wd_a = wd; div_a = dv;
      tn = cyc;
      @(negedge clk);
      rd_a = 1'b0; wr_a = 1'b0; addr_a = 16'hFFFF; wd_a = 32'h0;
      chk("ready_drop", 128'(rdy_a), 128'd0);
      if (rd && !wr) chk("valid_clear", 128'(vld_a), 128'd0);
   endtask

   // Follow one frame on A and check its timing and end-of-frame outputs.
   task automatic frame_a(input int tn, input int dv, input int n, input logic v_fall,
                          input logic v_end, input logic [31:0] rd_end);
      int d;
      d = (dv == 0) ? 1 : dv;
      wait_until(0, 1'b0, "cs_fall_a");
      chk("cs_fall_cycle", 128'(cyc - tn), 128'd2);
      chk("valid_in_frame", 128'(vld_a), 128'(v_fall));
      wait_until(0, 1'b1, "cs_rise_a");
      chk("cs_rise_cycle", 128'(cyc - tn), 128'(2 + 2 * d * n));
      chk("valid_at_end", 128'(vld_a), 128'(v_end));
      chk("read_data_at_end", 128'(rdt_a), 128'(rd_end));
      chk("sclk_idle_at_end", 128'(sclk_a), 128'd0);
      wait_until(1, 1'b1, "ready_a");
      chk("ready_cycle", 128'(cyc - tn), 128'(3 + 2 * d * n));
   endtask

   initial begin
      int tn, c1, c2;

      // Reset values.
      repeat (3) @(negedge clk);
      chk("rst_sclk", 128'(sclk_a), 128'd0);
      chk("rst_cs_n", 128'(csn_a), 128'd1);
      chk("rst_di", 128'(di_a), 128'd0);
      chk("rst_ready", 128'(rdy_a), 128'd0);
      chk("rst_valid", 128'(vld_a), 128'd0);
      chk("rst_read_data", 128'(rdt_a), 128'd0);

      // Init frame at D=1.
      rst_a = 1'b0;
      rst_b = 1'b0;
      wait_until(0, 1'b0, "init_cs_fall");
      c1 = cyc;
      wait_until(0, 1'b1, "init_cs_rise");
      c2 = cyc;
      chk("init_cs_low_len", 128'(c2 - c1), 128'd32);
      chk("init_frame", 128'(a_last[15:0]), 128'h0141);
      chk("init_bits", 128'(a_last_n), 128'd16);
      wait_until(1, 1'b1, "init_ready");
      chk("init_ready_delay", 128'(cyc - c1), 128'd34);

      // Write 0xDEADBEEF to 0x0010 at D=2.
      issue_a(1'b0, 1'b1, 16'h0010, 32'hDEADBEEF, 16'd2, tn);
      frame_a(tn, 2, 56, 1'b0, 1'b0, 32'h0);
      chk("write_stream", a_last[55:0], 128'h02_0010_DEADBEEF);
      chk("write_bits", 128'(a_last_n), 128'd56);
      chk("write_per_min", 128'(per_min), 128'd4);
      chk("write_per_max", 128'(per_max), 128'd4);

      // Read it back at D=1.
      issue_a(1'b1, 1'b0, 16'h0010, 32'h0, 16'd1, tn);
      frame_a(tn, 1, 56, 1'b0, 1'b1, 32'hDEADBEEF);
      chk("read_cmd", 128'(a_last[55:48]), 128'h03);
      chk("read_addr", 128'(a_last[47:32]), 128'h0010);

      // Both ops at once: write wins, valid and read_data untouched.
      issue_a(1'b1, 1'b1, 16'h0020, 32'h12345678, 16'd1, tn);
      frame_a(tn, 1, 56, 1'b1, 1'b1, 32'hDEADBEEF);
      chk("both_cmd", 128'(a_last[55:48]), 128'h02);
      chk("both_data", 128'(a_last[31:0]), 128'h12345678);

      // sclk_div=0 behaves like 1.
      issue_a(1'b1, 1'b0, 16'h0020, 32'h0, 16'd0, tn);
      frame_a(tn, 0, 56, 1'b0, 1'b1, 32'h12345678);
      chk("div0_per_min", 128'(per_min), 128'd2);
      chk("div0_per_max", 128'(per_max), 128'd2);

      // Divider change mid-frame has no effect until the next frame.
      issue_a(1'b1, 1'b0, 16'h0010, 32'h0, 16'd3, tn);
      wait_until(0, 1'b0, "div3_cs_fall");
      repeat (20) @(negedge clk);
      div_a = 16'd1;
      wait_until(0, 1'b1, "div3_cs_rise");
      chk("div3_frame_len", 128'(cyc - tn), 128'(2 + 6 * 56));
      chk("div3_per_min", 128'(per_min), 128'd6);
      chk("div3_per_max", 128'(per_max), 128'd6);
      chk("div3_read_data", 128'(rdt_a), 128'hDEADBEEF);

      // Reset pulsed in the middle of a read.
      issue_a(1'b1, 1'b0, 16'h0010, 32'h0, 16'd2, tn);
      wait_until(0, 1'b0, "mid_cs_fall");
      repeat (60) @(negedge clk);
      #2 rst_a = 1'b1;
      #1;
      chk("midrst_cs_n", 128'(csn_a), 128'd1);
      chk("midrst_sclk", 128'(sclk_a), 128'd0);
      chk("midrst_ready", 128'(rdy_a), 128'd0);
      chk("midrst_valid", 128'(vld_a), 128'd0);
      chk("midrst_read_data", 128'(rdt_a), 128'd0);
      @(negedge clk);
      rst_a = 1'b0;
      wait_until(0, 1'b0, "reinit_cs_fall");
      wait_until(0, 1'b1, "reinit_cs_rise");
      chk("reinit_frame", 128'(a_last[15:0]), 128'h0141);
      chk("reinit_bits", 128'(a_last_n), 128'd16);
      issue_a(1'b1, 1'b0, 16'h0010, 32'h0, 16'd1, tn);
      frame_a(tn, 1, 56, 1'b0, 1'b1, 32'hDEADBEEF);

      // Wide instance: write then read a 64-bit word.
      wait_until(3, 1'b1, "ready_b");
      wr_b = 1'b1; addr_b = 24'h123456; wd_b = 64'h0123456789ABCDEF; div_b = 16'd1;
      @(negedge clk);
      wr_b = 1'b0; addr_b = '0; wd_b = '0;
      wait_until(2, 1'b0, "b_wr_cs_fall");
      wait_until(2, 1'b1, "b_wr_cs_rise");
      chk("b_write_bits", 128'(b_last_n), 128'd96);
      chk("b_write_stream", b_last[95:0], 128'h02_123456_0123456789ABCDEF);
      chk("b_write_valid", 128'(vld_b), 128'd0);
      wait_until(3, 1'b1, "ready_b2");
      rd_b = 1'b1; addr_b = 24'h123456;
      @(negedge clk);
      rd_b = 1'b0; addr_b = '0;
      wait_until(2, 1'b0, "b_rd_cs_fall");
      wait_until(2, 1'b1, "b_rd_cs_rise");
      chk("b_read_bits", 128'(b_last_n), 128'd96);
      chk("b_read_cmd", 128'(b_last[95:88]), 128'h03);
      chk("b_read_valid", 128'(vld_b), 128'd1);
      chk("b_read_data", 128'(rdt_b), 128'h0123456789ABCDEF);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mkmif_gen_core.md
# mkmif_gen_core

Parametrised Master Key Memory interface core for the serial SRAM. It acts as a SPI master with an integrated shift engine and SCLK divider. Word width, address width and the mode byte written at init are generics. It sits between the mkmif register front-end and the external SRAM, and performs one word read or write per command.

## Interface
- DATA_BYTES, 4: bytes per data word; `read_data`/`write_data` are 8*DATA_BYTES bits.
- ADDR_BYTES, 2: address bytes sent after the command byte; `addr` is 8*ADDR_BYTES bits.
- DIV_WIDTH, 16: width of `sclk_div`.
- INIT_MODE, 8'h41: status byte written at init (sequential mode, no hold).
- Clock and reset: one clock; reset is asynchronous and active-high.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- spi_sclk  out  1  SPI clock, mode 0.
- spi_cs_n  out  1  chip select, active low.
- spi_do  in  1  serial data from SRAM.
- spi_di  out  1  serial data to SRAM, MSB first.
- read_op  in  1  read request, sampled only while `ready`=1.
- write_op  in  1  write request, sampled only while `ready`=1.
- ready  out  1  core idle and accepting a command.
- valid  out  1  `read_data` holds the result of the last completed read.
- sclk_div  in  DIV_WIDTH  SCLK half-period in clk cycles (D); 0 is treated as 1.
- addr  in  8*ADDR_BYTES  word address.
- write_data  in  8*DATA_BYTES  write word.
- read_data  out  8*DATA_BYTES  last read word.

## Operation
- Reset values:
  - `spi_sclk`=0, `spi_cs_n`=1, `spi_di`=0.
  - `ready`=0, `valid`=0, `read_data`=0.
  - FSM in INIT.
- FSM states:
  - INIT: queue an init frame, go to LOAD.
  - READY: `ready`=1; a command is accepted here.
  - LOAD: latch D, the frame and bit count N; go to SHIFT.
  - SHIFT: run the bit serialiser.
  - DONE: go to READY.
- Init frame: {8'h01, INIT_MODE}, N=16.
- Read frame: {8'h03, addr, DATA_BYTES zero bytes}, N=8*(1+ADDR_BYTES+DATA_BYTES).
  - The last 8*DATA_BYTES sampled `spi_do` bits form the read word.
- Write frame: {8'h02, addr, write_data}, same N as a read.
- Accepting a command:
  - `addr`, `write_data` and `sclk_div` are captured in the accept cycle; later input changes do not affect the frame.
  - `read_op` and `write_op` both high: the write wins and the read is dropped.
  - Read accept clears `valid` in the next cycle.
  - A write leaves `valid` and `read_data` unchanged.
  - Ops while `ready`=0 are ignored; they are not queued.
- SHIFT, per bit:
  - `spi_di` holds the bit for 2D cycles.
  - `spi_sclk` is low for D cycles, then high for D cycles.
  - `spi_do` is sampled in the cycle in which `spi_sclk` rises.
  - After the Nth high phase: `spi_sclk`=0, `spi_cs_n`=1, `spi_di`=0.
- End of a read: `read_data` is updated and `valid`=1 in the same cycle that `spi_cs_n` rises.
- Bit counter width: clog2 of the maximum N plus 1.
- Divider counter: DIV_WIDTH bits, wraps to 0 at D-1.

## Timing
- Init: the first cycle after reset deasserts, the core is in INIT; `spi_cs_n` falls 2 cycles later.
  - `ready` rises 2D*16+2 cycles after `spi_cs_n` falls.
- Command accepted in cycle t:
  - `ready`=0 at t+1.
  - `spi_cs_n`=0 and the first `spi_di` bit appear at t+2.
  - `spi_cs_n`=1 at t+2+2D*N.
  - `ready`=1 at t+3+2D*N. Next accept at the earliest in that cycle.
- `ready` is never high while `spi_cs_n`=0.
- Reset asserted mid-frame:
  - All outputs take their reset values immediately (async).
  - The frame is abandoned and `valid`=0.
  - Init re-runs after release.
- `sclk_div` is changeable at any time; it is applied only at the next LOAD.

## Test plan
- Reset release, D=1: expect init frame bits 0x01 0x41 on `spi_di`.
  - `spi_cs_n` low for 32 cycles; `ready` rises 34 cycles after `spi_cs_n` falls.
- Write, addr=0x0010, data=0xDEADBEEF, D=2: expect `spi_di` stream 02 00 10 DE AD BE EF (56 bits).
  - 224-cycle frame; `valid` unchanged.
- Read, addr=0x0010, SRAM model returning 0xDEADBEEF: `read_data`=0xDEADBEEF, `valid`=1 when `spi_cs_n` rises.
  - `valid`=0 during the frame.
- `read_op` and `write_op` high in the same cycle: only a write frame (command 0x02) is issued; `valid` stays unchanged.
- `sclk_div`=0 behaves like `sclk_div`=1.
  - Changing `sclk_div` from 3 to 1 mid-frame keeps 6-cycle bit periods until the frame ends.
- Reset pulsed halfway through a read: `spi_cs_n`=1, `spi_sclk`=0, `ready`=0, `valid`=0 at once.
  - The init frame repeats after release; a following read returns correct data.
- DATA_BYTES=8, ADDR_BYTES=3 instance: read frame is N=96 bits and the 64-bit word round-trips through write then read.
